floating_point_fma_scheduler: RTL and testbench
===============================================

FLOATING_POINT_FMA_SCHEDULER -- requirements
Module: floating_point_fma_scheduler

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 4, meaning fixed cycles from mul_valid_o to mul_valid_i (>=1).
REQ-002 SHALL have parameter ADD_LATENCY, default 3, meaning fixed cycles from add_valid_o to add_valid_i (>=1).
REQ-003 SHALL have parameter TAG_WIDTH, default 4, meaning width of the per-operation tag.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries (power of 2, >=2).
REQ-005 SHALL have ports clk_i in 1 (clock); rst_n_i in 1 (reset, asynchronous active-low); clk_en_i in 1 (state advances only when 1).
REQ-006 SHALL have issue ports valid_i in 1; ready_o out 1; op_i in 2 (00 MUL a*b, 01 ADD a+b, 10 FMADD a*b+c, 11 FNMADD -(a*b)+c); operand_1_i, operand_2_i, operand_3_i in 32 each (float32); tag_i in TAG_WIDTH.
REQ-007 SHALL have multiplier ports mul_valid_o out 1; mul_op_a_o, mul_op_b_o out 32; mul_valid_i in 1; mul_result_i in 32.
REQ-008 SHALL have adder ports add_valid_o out 1; add_op_a_o, add_op_b_o out 32; add_valid_i in 1; add_result_i in 32.
REQ-009 SHALL have result ports valid_o out 1; ready_i in 1; result_o out 32; tag_o out TAG_WIDTH.

Function
REQ-010 SHALL accept an operation when valid_i & ready_o & clk_en_i in the same cycle.
REQ-011 SHALL drive ready_o = clk_en_i & ~hazard & (fifo_count + inflight < FIFO_DEPTH), hazard = fused entry at multiplier-tracking stage MUL_LATENCY with op_i = ADD.
REQ-012 SHALL, on accepted MUL/FMADD/FNMADD, assert mul_valid_o combinationally with mul_op_a_o = operand_1_i, mul_op_b_o = operand_2_i.
REQ-013 SHALL carry tag, fused flag, negate flag and operand_3 through a MUL_LATENCY-deep shift register advanced on clk_en_i.
REQ-014 SHALL, when mul_valid_i and the tracked entry is fused, issue to the adder in that cycle: add_op_a_o = mul_result_i with bit 31 inverted if negate, add_op_b_o = tracked operand_3.
REQ-015 SHALL, on accepted ADD with no fused issue pending, issue to the adder in that cycle: add_op_a_o = operand_1_i, add_op_b_o = operand_2_i.
REQ-016 SHALL carry the adder-issue tag through an ADD_LATENCY-deep shift register and pair it with add_result_i on add_valid_i.
REQ-017 SHALL write a non-fused mul_valid_i result and an add_valid_i result into the FIFO in the same cycle, multiplier result first.
REQ-018 SHALL count inflight as accepted-not-yet-written operations (FMADD counts once), +1 per accept, -0/1/2 per FIFO write.
REQ-019 SHALL present FIFO head on result_o/tag_o with valid_o = ~empty; pop on valid_o & ready_i & clk_en_i; pop and write in the same cycle both take effect.
REQ-020 SHALL never overflow the FIFO (guaranteed by REQ-011 credit); read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 SHALL return results possibly out of issue order; tag_o identifies each.
REQ-022 SHALL, when clk_en_i = 0, hold all state, deassert ready_o; mul_valid_o/add_valid_o SHALL be 0.
REQ-023 SHALL flag an assertion if mul_valid_i or add_valid_i disagrees with its tracking pipe valid bit.

Reset
REQ-024 SHALL, on rst_n_i low (asynchronous), clear tracking pipes, FIFO pointers, fifo_count and inflight to 0.
REQ-025 SHALL drive during/after reset valid_o = 0, mul_valid_o = 0, add_valid_o = 0, result_o = 0, tag_o = 0; ready_o = clk_en_i.
REQ-026 SHALL discard all in-flight operations on reset mid-operation; late mul_valid_i/add_valid_i after reset SHALL be ignored.

Verification
REQ-027 SHALL pass: MUL 2.0*3.0 tag 1 at cycle 0, ready_i=1 -> valid_o at cycle MUL_LATENCY+1, result_o = 0x40C00000, tag_o = 1.
REQ-028 SHALL pass: FMADD 2.0*3.0+1.0 tag 2 -> one result 0x40E00000 tag 2 after MUL_LATENCY+ADD_LATENCY+1 cycles; FNMADD same operands -> 0xC0A00000.
REQ-029 SHALL pass: FMADD at cycle 0, ADD offered at cycle MUL_LATENCY -> ready_o = 0 that cycle, ADD accepted next cycle, both results delivered.
REQ-030 SHALL pass: ready_i = 0, FIFO_DEPTH MULs issued -> ready_o drops after 4th accept, rises one cycle after first pop, no result lost.
REQ-031 SHALL pass: MUL at cycle 0, ADD at cycle MUL_LATENCY-ADD_LATENCY -> simultaneous writes, MUL result popped first, then ADD.
REQ-032 SHALL pass: reset asserted with 3 ops in flight -> valid_o = 0, inflight = 0, ready_o = 1 after release, no stale outputs.

Source files
------------

// File: rtl/floating_point_fma_scheduler.sv
// Issue scheduler pairing an external pipelined multiplier and adder into MUL/ADD/FMADD/FNMADD,
// with tag tracking through both units and a credit-protected output FIFO.
module floating_point_fma_scheduler #(
  parameter int MUL_LATENCY = 4,
  parameter int ADD_LATENCY = 3,
  parameter int TAG_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clk_en_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           op_i,
  input  logic [31:0]          operand_1_i,
  input  logic [31:0]          operand_2_i,
  input  logic [31:0]          operand_3_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 mul_valid_o,
  output logic [31:0]          mul_op_a_o,
  output logic [31:0]          mul_op_b_o,
  input  logic                 mul_valid_i,
  input  logic [31:0]          mul_result_i,
  output logic                 add_valid_o,
  output logic [31:0]          add_op_a_o,
  output logic [31:0]          add_op_b_o,
  input  logic                 add_valid_i,
  input  logic [31:0]          add_result_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          result_o,
  output logic [TAG_WIDTH-1:0] tag_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_ADD = 2'b01, OP_FMADD = 2'b10, OP_FNMADD = 2'b11} op_e;

  typedef struct packed {
    logic                 valid;
    logic                 fused;
    logic                 negate;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          op3;
  } mul_trk_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } add_trk_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          data;
  } entry_t;

  mul_trk_t             mul_pipe [1:MUL_LATENCY];
  add_trk_t             add_pipe [1:ADD_LATENCY];
  entry_t               fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, wr_ptr_nxt;
  logic [CW-1:0]        fifo_count, inflight;
  mul_trk_t             mul_head;
  add_trk_t             add_head;
  entry_t               head_entry;
  logic                 hazard, credit_ok, accept, fused_issue, add_direct;
  logic                 mul_wr, add_wr, pop;
  logic [1:0]           wr_num;
  logic [TAG_WIDTH-1:0] add_tag;

  assign mul_head = mul_pipe[MUL_LATENCY];
  assign add_head = add_pipe[ADD_LATENCY];

  // A fused op reaching the adder this cycle owns the adder port, so a direct ADD must wait.
  assign hazard    = mul_head.valid & mul_head.fused & (op_e'(op_i) == OP_ADD);
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign ready_o   = clk_en_i & ~hazard & credit_ok;
  assign accept    = valid_i & ready_o;

  assign mul_valid_o = accept & (op_e'(op_i) != OP_ADD);
  assign mul_op_a_o  = operand_1_i;
  assign mul_op_b_o  = operand_2_i;

  assign fused_issue = clk_en_i & mul_valid_i & mul_head.valid & mul_head.fused;
  assign add_direct  = accept & (op_e'(op_i) == OP_ADD);
  assign add_valid_o = fused_issue | add_direct;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    add_op_a_o = operand_1_i;
    add_op_b_o = operand_2_i;
    add_tag    = tag_i;
    if (fused_issue) begin
      add_op_a_o = {mul_result_i[31] ^ mul_head.negate, mul_result_i[30:0]};
      add_op_b_o = mul_head.op3;
      add_tag    = mul_head.tag;
    end
  end

  assign mul_wr     = clk_en_i & mul_valid_i & mul_head.valid & ~mul_head.fused;
  assign add_wr     = clk_en_i & add_valid_i & add_head.valid;
  assign wr_num     = {1'b0, mul_wr} + {1'b0, add_wr};
  assign wr_ptr_nxt = wr_ptr + PW'(1);

  assign valid_o    = (fifo_count != '0);
  assign pop        = valid_o & ready_i & clk_en_i;
  assign head_entry = fifo_mem[rd_ptr];
  assign result_o   = valid_o ? head_entry.data : '0;
  assign tag_o      = valid_o ? head_entry.tag  : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i <= MUL_LATENCY; i++) mul_pipe[i] <= '0;
      for (int i = 1; i <= ADD_LATENCY; i++) add_pipe[i] <= '0;
    end else if (clk_en_i) begin
      // NOTE: non-blocking assignments let each stage sample its predecessor's old value.
      mul_pipe[1] <= '{valid: mul_valid_o, fused: op_i[1],
                       negate: (op_e'(op_i) == OP_FNMADD), tag: tag_i, op3: operand_3_i};
      for (int i = 2; i <= MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
      add_pipe[1] <= '{valid: add_valid_o, tag: add_tag};
      for (int i = 2; i <= ADD_LATENCY; i++) add_pipe[i] <= add_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(wr_num);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_count <= fifo_count + CW'(wr_num) - CW'(pop);
      inflight   <= inflight + CW'(accept) - CW'(wr_num);
    end
  end

  // NOTE: storage is not reset; result_o/tag_o are masked by valid_o so stale entries never show.
  always_ff @(posedge clk_i) begin
    if (mul_wr) fifo_mem[wr_ptr] <= '{tag: mul_head.tag, data: mul_result_i};
    if (add_wr) fifo_mem[mul_wr ? wr_ptr_nxt : wr_ptr] <= '{tag: add_head.tag, data: add_result_i};
  end

  mul_track_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    clk_en_i |-> (mul_valid_i == mul_head.valid));
  add_track_a: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    clk_en_i |-> (add_valid_i == add_head.valid));
endmodule

// File: tb/tb_floating_point_fma_scheduler.sv
// Bench for floating_point_fma_scheduler: fixed-latency behavioural FP units plus a tag-keyed scoreboard.
module tb_floating_point_fma_scheduler;
  localparam int ML = 4;
  localparam int AL = 3;
  localparam int TW = 4;
  localparam int FD = 4;

  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1;
  logic valid_i = 1'b0, ready_o, ready_i = 1'b1;
  logic [1:0] op_i = 2'b00;
  logic [31:0] operand_1 = '0, operand_2 = '0, operand_3 = '0;
  logic [TW-1:0] tag_i = '0, tag_o;
  logic mul_valid_o, mul_valid_i, add_valid_o, add_valid_i, valid_o;
  logic [31:0] mul_op_a, mul_op_b, mul_result, add_op_a, add_op_b, add_result, result_o;

  int checks = 0, failures = 0;

  floating_point_fma_scheduler #(.MUL_LATENCY(ML), .ADD_LATENCY(AL), .TAG_WIDTH(TW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en),
    .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .operand_1_i(operand_1), .operand_2_i(operand_2), .operand_3_i(operand_3), .tag_i(tag_i),
    .mul_valid_o(mul_valid_o), .mul_op_a_o(mul_op_a), .mul_op_b_o(mul_op_b),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result),
    .add_valid_o(add_valid_o), .add_op_a_o(add_op_a), .add_op_b_o(add_op_b),
    .add_valid_i(add_valid_i), .add_result_i(add_result),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Float32 <-> real conversion for normal numbers and zero; enough for behavioural units.
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real  a;
    int   e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // Behavioural fixed-latency multiplier and adder, stalled by clk_en like the scheduler.
  logic        mv [ML];
  logic [31:0] mr [ML];
  logic        av [AL];
  logic [31:0] ar [AL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ML; i++) begin mv[i] <= 1'b0; mr[i] <= '0; end
      for (int i = 0; i < AL; i++) begin av[i] <= 1'b0; ar[i] <= '0; end
    end else if (clk_en) begin
      mv[0] <= mul_valid_o;
      mr[0] <= mul_valid_o ? fmul(mul_op_a, mul_op_b) : 32'h0;
      for (int i = 1; i < ML; i++) begin mv[i] <= mv[i-1]; mr[i] <= mr[i-1]; end
      av[0] <= add_valid_o;
      ar[0] <= add_valid_o ? fadd(add_op_a, add_op_b) : 32'h0;
      for (int i = 1; i < AL; i++) begin av[i] <= av[i-1]; ar[i] <= ar[i-1]; end
    end
  end

  assign mul_valid_i = clk_en & mv[ML-1];
  assign mul_result  = mr[ML-1];
  assign add_valid_i = clk_en & av[AL-1];
  assign add_result  = ar[AL-1];

  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   res;
  } exp_t;

  exp_t          sb[$];
  logic [TW-1:0] out_tags[$];

  // Results may leave out of order, so match each pop against the scoreboard by tag.
  always @(negedge clk) begin
    if (rst_n && clk_en && valid_o && ready_i) begin
      int idx;
      idx = -1;
      foreach (sb[i]) if (idx < 0 && sb[i].tag == tag_o) idx = i;
      check("tag_expected", 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check($sformatf("result_tag%0d", tag_o), result_o, sb[idx].res);
        sb.delete(idx);
      end
      out_tags.push_back(tag_o);
    end
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    logic [31:0] p;
    p = fmul(a, b);
    case (op)
      2'b00:   return p;
      2'b01:   return fadd(a, b);
      2'b10:   return fadd(p, c);
      default: return fadd({~p[31], p[30:0]}, c);
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 of the next cycle with valid_i dropped.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [TW-1:0] tag, output bit ok);
    valid_i = 1'b1; op_i = op; operand_1 = a; operand_2 = b; operand_3 = c; tag_i = tag;
    #1;
    ok = ready_o;
    if (ok) sb.push_back('{tag: tag, res: model(op, a, b, c)});
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin @(posedge clk); #1; k++; end
    check("drain_complete", 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] F0_5 = 32'h3F000000, F1 = 32'h3F800000, F1_5 = 32'h3FC00000;
  localparam logic [31:0] F2 = 32'h40000000, F2_5 = 32'h40200000, F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000, FM2 = 32'hC0000000;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base;

    #2;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_result_o", result_o, 32'h0);
    check("rst_tag_o", 32'(tag_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_mul_valid_o", 32'(mul_valid_o), 32'd0);
    check("rst_add_valid_o", 32'(add_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // MUL latency: accepted in cycle 0, visible in cycle ML+1.
    issue(2'b00, F2, F3, 32'h0, 4'd1, ok);
    check("mul_accept", 32'(ok), 32'd1);
    idle(ML - 1);
    check("mul_not_early", 32'(valid_o), 32'd0);
    idle(1);
    check("mul_valid_o", 32'(valid_o), 32'd1);
    check("mul_result", result_o, 32'h40C00000);
    check("mul_tag", 32'(tag_o), 32'd1);
    idle(2);

    // FMADD then FNMADD, each visible ML+AL+1 cycles after accept.
    issue(2'b10, F2, F3, F1, 4'd2, ok);
    idle(ML + AL - 1);
    check("fmadd_not_early", 32'(valid_o), 32'd0);
    idle(1);
    check("fmadd_result", result_o, 32'h40E00000);
    check("fmadd_tag", 32'(tag_o), 32'd2);
    idle(2);
    issue(2'b11, F2, F3, F1, 4'd3, ok);
    idle(ML + AL);
    check("fnmadd_result", result_o, 32'hC0A00000);
    check("fnmadd_tag", 32'(tag_o), 32'd3);
    idle(2);

    // ADD offered while the fused op claims the adder is held off one cycle.
    issue(2'b10, F1_5, F2, F1, 4'd4, ok);
    idle(ML - 1);
    issue(2'b01, F1_5, F2_5, 32'h0, 4'd5, ok);
    check("hazard_blocks_add", 32'(ok), 32'd0);
    issue(2'b01, F1_5, F2_5, 32'h0, 4'd5, ok);
    check("add_after_hazard", 32'(ok), 32'd1);
    wait_drain(40);

    // Back-pressure: FD MULs fill the credit, one pop releases it a cycle later.
    ready_i = 1'b0;
    issue(2'b00, F1_5, F2, 32'h0, 4'd6, ok); check("bp_accept0", 32'(ok), 32'd1);
    issue(2'b00, F3, F3, 32'h0, 4'd7, ok);   check("bp_accept1", 32'(ok), 32'd1);
    issue(2'b00, F0_5, F4, 32'h0, 4'd8, ok); check("bp_accept2", 32'(ok), 32'd1);
    issue(2'b00, FM2, F2_5, 32'h0, 4'd9, ok); check("bp_accept3", 32'(ok), 32'd1);
    check("bp_ready_low", 32'(ready_o), 32'd0);
    idle(ML);
    check("bp_still_low", 32'(ready_o), 32'd0);
    check("bp_valid_o", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    #1;
    check("bp_low_during_pop", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("bp_ready_rises", 32'(ready_o), 32'd1);
    ready_i = 1'b1;
    wait_drain(40);

    // Simultaneous MUL and ADD writes: MUL result leaves first.
    base = out_tags.size();
    issue(2'b00, F2, F2_5, 32'h0, 4'd10, ok);
    idle(ML - AL - 1);
    issue(2'b01, F1, F3, 32'h0, 4'd11, ok);
    idle(AL);
    check("sim_first_tag", 32'(tag_o), 32'd10);
    idle(1);
    check("sim_second_tag", 32'(tag_o), 32'd11);
    wait_drain(20);
    check("sim_order_count", 32'(out_tags.size() - base), 32'd2);

    // clk_en low: ready_o and unit handshakes forced low, in-flight work stalls and resumes.
    issue(2'b00, F3, F4, 32'h0, 4'd12, ok);
    clk_en = 1'b0;
    valid_i = 1'b1; op_i = 2'b00; tag_i = 4'd13;
    #1;
    check("cken_ready_low", 32'(ready_o), 32'd0);
    check("cken_mul_valid_low", 32'(mul_valid_o), 32'd0);
    valid_i = 1'b0;
    idle(ML + 2);
    check("cken_held", 32'(valid_o), 32'd0);
    clk_en = 1'b1;
    wait_drain(20);

    // Reset with three ops in flight: everything is discarded.
    issue(2'b00, F2, F2, 32'h0, 4'd13, ok);
    issue(2'b10, F2, F3, F1, 4'd14, ok);
    issue(2'b01, F1, F1, 32'h0, 4'd15, ok);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_ready_o", 32'(ready_o), 32'd1);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < ML + AL + 3; i++) begin
      check($sformatf("postrst_quiet%0d", i), 32'(valid_o), 32'd0);
      idle(1);
    end
    check("postrst_ready_o", 32'(ready_o), 32'd1);
    issue(2'b00, F1_5, F1_5, 32'h0, 4'd1, ok);
    check("postrst_accept", 32'(ok), 32'd1);
    wait_drain(20);

    idle(2);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
